// File: rtl/ms_delay_countdown.sv
// ms_delay_countdown: millisecond delay counter on the consumer side of the 1 ms tick interface.
// It drives the tick generator's TimerEnable and counts Tick pulses down from DelayMs.
// When the delay expires it emits a single-cycle Done pulse.
// Optional macro DELAY_PERIODIC_EN adds a Periodic input that makes the delay reload on expiry.
module ms_delay_countdown #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Abort,
    input  logic [WIDTH-1:0] DelayMs,
    input  logic             Tick,
`ifdef DELAY_PERIODIC_EN
    input  logic             Periodic,
`endif
    output logic             TimerEnable,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Remaining
);

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StRun
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             done_ev;
    logic             en_q, busy_q;
    logic             reload_ok;

    // On expiry, a nonzero DelayMs lets the periodic mode keep running without a SYNC cycle.
`ifdef DELAY_PERIODIC_EN
    assign reload_ok = Periodic && (DelayMs != '0);
`else
    assign reload_ok = 1'b0;
`endif

    // Next-state, remaining count and Done decision; priority is Abort > Start > Tick.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_ev = 1'b0;
        if ((state_q != StIdle) && Abort) begin
            state_d = StIdle;
            rem_d   = '0;
        end else if (Start) begin
            if (DelayMs == '0) begin
                state_d = StIdle;
                rem_d   = '0;
                done_ev = 1'b1;
            end else begin
                state_d = StSync;
                rem_d   = DelayMs;
            end
        end else begin
            unique case (state_q)
                StSync: state_d = StRun;
                StRun: begin
                    if (Tick) begin
                        if (rem_q > WIDTH'(1)) begin
                            rem_d = rem_q - WIDTH'(1);
                        end else begin
                            done_ev = 1'b1;
                            if (reload_ok) begin
                                rem_d = DelayMs;
                            end else begin
                                state_d = StIdle;
                                rem_d   = '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
        // Done must never be high for two consecutive cycles.
        done_d = done_ev && !done_q;
    end

    // State and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            en_q    <= (state_d == StRun);
            busy_q  <= (state_d != StIdle);
        end
    end

    assign TimerEnable = en_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Remaining   = rem_q;

endmodule

// File: tb/tb_ms_delay_countdown.sv
// Testbench for ms_delay_countdown: directed scenarios plus randomized traffic.
// Every cycle is compared against a behavioural model of the delay counter.
module tb_ms_delay_countdown;

    localparam int unsigned W = 16;

    logic         Clk = 1'b0;
    logic         Rst, Start, Abort, Tick, Periodic;
    logic [W-1:0] DelayMs;
    logic         TimerEnable, Busy, Done;
    logic [W-1:0] Remaining;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model: phase 0 idle, 1 = enable-low sync cycle, 2 = counting.
    int m_phase = 0;
    int m_rem   = 0;
    bit m_done  = 1'b0;
    bit per_en;

    always #5 Clk = ~Clk;

    ms_delay_countdown #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .Abort      (Abort),
        .DelayMs    (DelayMs),
        .Tick       (Tick),
`ifdef DELAY_PERIODIC_EN
        .Periodic   (Periodic),
`endif
        .TimerEnable(TimerEnable),
        .Busy       (Busy),
        .Done       (Done),
        .Remaining  (Remaining)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit rst, input bit start, input bit abort,
                                input int delay, input bit tick, input bit per);
        bit ev = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_rem   = 0;
            m_done  = 1'b0;
            return;
        end
        if (m_phase != 0 && abort) begin
            m_phase = 0;
            m_rem   = 0;
        end else if (start) begin
            if (delay == 0) begin
                ev      = 1'b1;
                m_phase = 0;
                m_rem   = 0;
            end else begin
                m_phase = 1;
                m_rem   = delay;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2 && tick) begin
            if (m_rem >= 2) begin
                m_rem = m_rem - 1;
            end else begin
                ev = 1'b1;
                if (per && delay != 0) begin
                    m_rem = delay;
                end else begin
                    m_phase = 0;
                    m_rem   = 0;
                end
            end
        end
        m_done = ev && !m_done;
    endtask

    // Apply one cycle of inputs, advance the model and compare all outputs after the edge.
    task automatic step(input bit rst, input bit start, input bit abort, input int delay,
                        input bit tick, input bit per);
        @(negedge Clk);
        Rst      = rst;
        Start    = start;
        Abort    = abort;
        DelayMs  = W'(delay);
        Tick     = tick;
        Periodic = per;
        @(posedge Clk);
        model_update(rst, start, abort, delay, tick, per && per_en);
        #1;
        check_eq("timer_en", int'(TimerEnable), int'(m_phase == 2));
        check_eq("busy", int'(Busy), int'(m_phase != 0));
        check_eq("done", int'(Done), int'(m_done));
        check_eq("remaining", int'(Remaining), m_rem);
    endtask

    task automatic idle_cycles(input int n, input int delay, input bit per);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, delay, 1'b0, per);
    endtask

    initial begin
`ifdef DELAY_PERIODIC_EN
        per_en = 1'b1;
`else
        per_en = 1'b0;
`endif
        Rst = 1'b1; Start = 1'b0; Abort = 1'b0; Tick = 1'b0; Periodic = 1'b0; DelayMs = '0;

        // Reset with Tick toggling.
        step(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 7, 1'b0, 1'b0);
        check_eq("rst_remaining", int'(Remaining), 0);
        check_eq("rst_busy", int'(Busy), 0);
        idle_cycles(2, 0, 1'b0);

        // DelayMs=3 with three Ticks spaced 10 cycles.
        step(1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0);
        check_eq("d3_sync_en", int'(TimerEnable), 0);
        check_eq("d3_sync_busy", int'(Busy), 1);
        idle_cycles(1, 3, 1'b0);
        check_eq("d3_run_en", int'(TimerEnable), 1);
        for (int t = 0; t < 3; t++) begin
            idle_cycles(9, 3, 1'b0);
            step(1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0);
            check_eq("d3_rem", int'(Remaining), 2 - t);
        end
        check_eq("d3_done", int'(Done), 1);
        check_eq("d3_busy_fall", int'(Busy), 0);
        idle_cycles(1, 3, 1'b0);
        check_eq("d3_done_once", int'(Done), 0);

        // Zero delay: immediate Done, enable never rises.
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check_eq("d0_done", int'(Done), 1);
        check_eq("d0_busy", int'(Busy), 0);
        idle_cycles(2, 0, 1'b0);
        check_eq("d0_en", int'(TimerEnable), 0);

        // Restart coincident with a Tick.
        step(1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0);
        idle_cycles(2, 5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0);
        idle_cycles(3, 5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0);
        check_eq("rs_rem3", int'(Remaining), 3);
        step(1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0);
        check_eq("rs_rem4", int'(Remaining), 4);
        check_eq("rs_sync", int'(TimerEnable), 0);
        check_eq("rs_nodone", int'(Done), 0);
        idle_cycles(1, 4, 1'b0);
        for (int t = 0; t < 4; t++) begin
            idle_cycles(4, 4, 1'b0);
            step(1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0);
        end
        check_eq("rs_done", int'(Done), 1);

        // Abort together with Start after one Tick.
        step(1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0);
        idle_cycles(2, 5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b0);
        check_eq("ab_busy", int'(Busy), 0);
        check_eq("ab_rem", int'(Remaining), 0);
        check_eq("ab_done", int'(Done), 0);
        for (int t = 0; t < 3; t++) step(1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0);

        // Periodic mode (only reloads when the feature is built in).
        step(1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b1);
        idle_cycles(1, 2, 1'b1);
        for (int t = 0; t < 6; t++) begin
            idle_cycles(3, 2, 1'b1);
            step(1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1);
            if (per_en && t % 2 == 1) begin
                check_eq("per_done", int'(Done), 1);
                check_eq("per_reload", int'(Remaining), 2);
                check_eq("per_en", int'(TimerEnable), 1);
            end
        end
        step(1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0);

        // Randomized traffic; Abort only while busy so its IDLE meaning stays unambiguous.
        for (int c = 0; c < 4000; c++) begin
            bit r, s, a, t, p;
            int d;
            r = ($urandom_range(0, 499) == 0);
            s = ($urandom_range(0, 29) == 0);
            a = (m_phase != 0) && ($urandom_range(0, 59) == 0);
            t = ($urandom_range(0, 4) == 0);
            p = $urandom_range(0, 1) != 0;
            d = $urandom_range(0, 6);
            step(r, s, a, d, t, p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
